// File: rtl/mips_prog_loader.sv
// Byte-stream program loader: packs big-endian bytes into 32-bit words, writes them from
// address 0 upward, and releases the CPU once an HLT word has been stored.
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | accepting bytes into the shift register
// WRITE | one-cycle memory write of the assembled word
// DONE  | HLT stored, cpu_run high
// ERR   | memory filled without HLT
module mips_prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_run
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_shift;
  logic [ADDR_W:0]   r_word_count;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic w_accept;
  logic w_last_byte;
  logic w_start_ok;
  logic w_hlt;
  logic w_full;

  assign w_accept    = (r_state == S_LOAD) && in_valid;
  assign w_last_byte = w_accept && (r_byte_cnt == 2'd3);
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_hlt       = (r_mem_wdata[31:26] == 6'h3f);
  assign w_full      = ((r_word_count + (ADDR_W+1)'(1)) == LP_DEPTH);

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LOAD;
      S_LOAD:                if (w_last_byte) w_next = S_WRITE;
      S_WRITE: begin
        // HLT wins over overflow: a program ending exactly at the last word is valid
        if (w_hlt)       w_next = S_DONE;
        else if (w_full) w_next = S_ERR;
        else             w_next = S_LOAD;
      end
      default:               w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_run  = 1'b0;
    case (r_state)
      S_LOAD:  begin in_ready = 1'b1; busy = 1'b1; end
      S_WRITE: busy = 1'b1;
      S_DONE:  begin done = 1'b1; cpu_run = 1'b1; end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      r_addr       <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_word_count <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_mem_we <= w_last_byte;
      if (w_start_ok) begin
        r_addr       <= '0;
        r_byte_cnt   <= '0;
        r_word_count <= '0;
      end
      if (w_accept) begin
        r_shift    <= {r_shift[23:0], in_data};
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_last_byte) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= {r_shift[23:0], in_data};
      end
      if (r_state == S_WRITE) begin
        r_addr       <= r_addr + ADDR_W'(1);
        r_word_count <= r_word_count + (ADDR_W+1)'(1);
      end
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Bench for mips_prog_loader: a default-depth instance and a DEPTH=4 instance, each checked
// every cycle against a transaction-level model of the loader.
module tb_mips_prog_loader;

  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;

  logic        clk1 = 1'b0;
  logic        reset;
  logic        s_start[2];
  logic        s_valid[2];
  logic [7:0]  s_data[2];
  logic        o_ready[2], o_we[2], o_busy[2], o_done[2], o_error[2], o_run[2];
  logic [9:0]  o_addr[2];
  logic [31:0] o_wdata[2];
  logic [10:0] o_wc[2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          m_st[2];
  bit          m_wr[2];
  logic [31:0] m_word[2], m_acc[2], m_last_data[2];
  int          m_nb[2], m_cnt[2];
  logic [9:0]  m_last_addr[2];

  logic [31:0] sb_mem[2][0:1023];
  int          sb_writes[2];
  int          last_we[2];

  logic [31:0] prog[9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                           32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

  always #5 clk1 = ~clk1;

  mips_prog_loader u_dut (
    .clk1(clk1), .reset(reset), .start(s_start[0]), .in_valid(s_valid[0]), .in_data(s_data[0]),
    .in_ready(o_ready[0]), .mem_we(o_we[0]), .mem_addr(o_addr[0]), .mem_wdata(o_wdata[0]),
    .word_count(o_wc[0]), .busy(o_busy[0]), .done(o_done[0]), .error(o_error[0]), .cpu_run(o_run[0]));

  mips_prog_loader #(.ADDR_W(10), .DEPTH(4)) u_ovf (
    .clk1(clk1), .reset(reset), .start(s_start[1]), .in_valid(s_valid[1]), .in_data(s_data[1]),
    .in_ready(o_ready[1]), .mem_we(o_we[1]), .mem_addr(o_addr[1]), .mem_wdata(o_wdata[1]),
    .word_count(o_wc[1]), .busy(o_busy[1]), .done(o_done[1]), .error(o_error[1]), .cpu_run(o_run[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_st[k] = M_IDLE; m_wr[k] = 1'b0; m_nb[k] = 0; m_cnt[k] = 0;
    m_acc[k] = '0; m_word[k] = '0; m_last_addr[k] = '0; m_last_data[k] = '0;
    last_we[k] = -100;
  endtask

  // Predicts the effect of the coming clock edge from the inputs presented this cycle.
  task automatic model_step(input int k);
    int depth;
    depth = (k == 0) ? 1024 : 4;
    if (m_wr[k]) begin
      m_last_addr[k] = 10'(m_cnt[k]);
      m_last_data[k] = m_word[k];
      m_cnt[k]++;
      m_wr[k] = 1'b0;
      if (m_word[k][31:26] == 6'h3f) m_st[k] = M_DONE;
      else if (m_cnt[k] == depth)    m_st[k] = M_ERR;
    end else if (m_st[k] != M_RUN) begin
      if (s_start[k]) begin m_st[k] = M_RUN; m_cnt[k] = 0; m_nb[k] = 0; end
    end else if (s_valid[k]) begin
      m_acc[k] = {m_acc[k][23:0], s_data[k]};
      m_nb[k]++;
      if (m_nb[k] == 4) begin m_word[k] = m_acc[k]; m_wr[k] = 1'b1; m_nb[k] = 0; end
    end
  endtask

  always @(negedge clk1) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) model_reset(k);
      chk($sformatf("in_ready%0d", k), 32'(o_ready[k]), 32'(m_st[k] == M_RUN && !m_wr[k]));
      chk($sformatf("mem_we%0d", k), 32'(o_we[k]), 32'(m_wr[k]));
      chk($sformatf("mem_addr%0d", k), 32'(o_addr[k]), m_wr[k] ? 32'(m_cnt[k]) : 32'(m_last_addr[k]));
      chk($sformatf("mem_wdata%0d", k), o_wdata[k], m_wr[k] ? m_word[k] : m_last_data[k]);
      chk($sformatf("word_count%0d", k), 32'(o_wc[k]), 32'(m_cnt[k]));
      chk($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(m_st[k] == M_RUN));
      chk($sformatf("done%0d", k), 32'(o_done[k]), 32'(m_st[k] == M_DONE));
      chk($sformatf("error%0d", k), 32'(o_error[k]), 32'(m_st[k] == M_ERR));
      chk($sformatf("cpu_run%0d", k), 32'(o_run[k]), 32'(m_st[k] == M_DONE));
      if (!reset) begin
        if (o_we[k]) begin
          chk($sformatf("we_spacing%0d", k), 32'(cyc - last_we[k] >= 5), 32'd1);
          last_we[k] = cyc;
          sb_mem[k][o_addr[k]] = o_wdata[k];
          sb_writes[k]++;
        end
        model_step(k);
      end
    end
  end

  task automatic sb_clear(input int k);
    for (int i = 0; i < 1024; i++) sb_mem[k][i] = 32'hdeadbeef;
    sb_writes[k] = 0;
  endtask

  task automatic pulse_start(input int k);
    s_start[k] = 1'b1;
    @(posedge clk1); #1;
    s_start[k] = 1'b0;
  endtask

  task automatic send_byte(input int k, input logic [7:0] b, input int gap, input int maxw, output bit ok);
    bit rdy;
    while (gap > 0 && $urandom_range(99) < gap) begin
      s_valid[k] = 1'b0; s_data[k] = 8'($urandom);
      @(posedge clk1); #1;
    end
    s_valid[k] = 1'b1; s_data[k] = b; ok = 1'b0;
    for (int i = 0; i < maxw; i++) begin
      @(negedge clk1); rdy = o_ready[k];
      @(posedge clk1); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    s_valid[k] = 1'b0;
  endtask

  task automatic send_bytes(input int k, input logic [31:0] w, input int nbytes, input int gap);
    bit ok;
    for (int i = 0; i < nbytes; i++) begin
      send_byte(k, w[31-8*i -: 8], gap, 50, ok);
      chk($sformatf("byte_accepted%0d", k), 32'(ok), 32'd1);
    end
  endtask

  task automatic wait_end(input int k, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      if (o_done[k] || o_error[k]) break;
      @(posedge clk1); #1;
    end
    chk($sformatf("end_reached%0d", k), 32'(i < maxc), 32'd1);
  endtask

  task automatic check_prog(input string nm, input int gap);
    sb_clear(0);
    pulse_start(0);
    for (int i = 0; i < 9; i++) send_bytes(0, prog[i], 4, gap);
    wait_end(0, 20);
    for (int i = 0; i < 9; i++) chk($sformatf("%s_mem[%0d]", nm, i), sb_mem[0][i], prog[i]);
    chk({nm, "_writes"}, 32'(sb_writes[0]), 32'd9);
    chk({nm, "_word_count"}, 32'(o_wc[0]), 32'd9);
    chk({nm, "_done"}, 32'(o_done[0]), 32'd1);
    chk({nm, "_cpu_run"}, 32'(o_run[0]), 32'd1);
    chk({nm, "_error"}, 32'(o_error[0]), 32'd0);
    chk({nm, "_in_ready"}, 32'(o_ready[0]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int k = 0; k < 2; k++) begin
      s_start[k] = 1'b0; s_valid[k] = 1'b0; s_data[k] = 8'h00;
      model_reset(k); sb_clear(k);
    end
    reset = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    chk("rst_word_count", 32'(o_wc[0]), 32'd0);
    chk("rst_cpu_run", 32'(o_run[0]), 32'd0);
    reset = 1'b0;
    @(posedge clk1); #1;

    // basic load; first byte is already valid on the start cycle and must not be taken there
    sb_clear(0);
    s_start[0] = 1'b1; s_valid[0] = 1'b1; s_data[0] = prog[0][31:24];
    @(posedge clk1); #1;
    s_start[0] = 1'b0;
    chk("start_cycle_no_accept_busy", 32'(o_busy[0]), 32'd1);
    for (int i = 0; i < 9; i++) send_bytes(0, prog[i], 4, 0);
    wait_end(0, 20);
    for (int i = 0; i < 9; i++) chk($sformatf("basic_mem[%0d]", i), sb_mem[0][i], prog[i]);
    chk("basic_writes", 32'(sb_writes[0]), 32'd9);
    chk("basic_word_count", 32'(o_wc[0]), 32'd9);
    chk("basic_done", 32'(o_done[0]), 32'd1);
    chk("basic_cpu_run", 32'(o_run[0]), 32'd1);
    chk("basic_error", 32'(o_error[0]), 32'd0);
    chk("basic_in_ready", 32'(o_ready[0]), 32'd0);

    // restart from DONE with an HLT-only program
    sb_clear(0);
    pulse_start(0);
    chk("restart_cpu_run", 32'(o_run[0]), 32'd0);
    chk("restart_done", 32'(o_done[0]), 32'd0);
    chk("restart_word_count", 32'(o_wc[0]), 32'd0);
    send_bytes(0, 32'hfc000000, 4, 0);
    wait_end(0, 20);
    chk("restart_mem0", sb_mem[0][0], 32'hfc000000);
    chk("restart_word_count_end", 32'(o_wc[0]), 32'd1);
    chk("restart_done_end", 32'(o_done[0]), 32'd1);

    check_prog("bp", 40);

    // start while busy is ignored
    sb_clear(0);
    pulse_start(0);
    send_bytes(0, 32'h2801000a, 3, 0);
    pulse_start(0);
    send_byte(0, 8'h0a, 0, 50, ok);
    chk("busy_byte4_accepted", 32'(ok), 32'd1);
    send_bytes(0, 32'hfc000000, 4, 0);
    wait_end(0, 20);
    chk("busy_mem0", sb_mem[0][0], 32'h2801000a);
    chk("busy_mem1", sb_mem[0][1], 32'hfc000000);
    chk("busy_writes", 32'(sb_writes[0]), 32'd2);

    // reset in the middle of word 1
    sb_clear(0);
    pulse_start(0);
    send_bytes(0, 32'h11223344, 4, 0);
    send_bytes(0, 32'h55667788, 2, 0);
    reset = 1'b1;
    #1;
    chk("midrst_we", 32'(o_we[0]), 32'd0);
    chk("midrst_addr", 32'(o_addr[0]), 32'd0);
    chk("midrst_wdata", o_wdata[0], 32'd0);
    chk("midrst_word_count", 32'(o_wc[0]), 32'd0);
    chk("midrst_busy", 32'(o_busy[0]), 32'd0);
    chk("midrst_in_ready", 32'(o_ready[0]), 32'd0);
    repeat (2) @(posedge clk1);
    #1;
    reset = 1'b0;
    chk("midrst_writes", 32'(sb_writes[0]), 32'd1);
    chk("midrst_mem0", sb_mem[0][0], 32'h11223344);
    sb_clear(0);
    pulse_start(0);
    send_bytes(0, 32'h12345678, 4, 20);
    send_bytes(0, 32'hfc000000, 4, 20);
    wait_end(0, 20);
    chk("postrst_mem0", sb_mem[0][0], 32'h12345678);
    chk("postrst_mem1", sb_mem[0][1], 32'hfc000000);
    chk("postrst_writes", 32'(sb_writes[0]), 32'd2);
    chk("postrst_done", 32'(o_done[0]), 32'd1);

    // overflow on the DEPTH=4 instance
    sb_clear(1);
    pulse_start(1);
    for (int w = 1; w <= 4; w++) send_bytes(1, 32'(w), 4, 10);
    wait_end(1, 20);
    send_byte(1, 8'h00, 0, 20, ok);
    chk("ovf_5th_rejected", 32'(ok), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("ovf_mem[%0d]", i), sb_mem[1][i], 32'(i + 1));
    chk("ovf_writes", 32'(sb_writes[1]), 32'd4);
    chk("ovf_error", 32'(o_error[1]), 32'd1);
    chk("ovf_done", 32'(o_done[1]), 32'd0);
    chk("ovf_cpu_run", 32'(o_run[1]), 32'd0);
    chk("ovf_word_count", 32'(o_wc[1]), 32'd4);

    // restart from ERR clears error
    pulse_start(1);
    chk("ovf_restart_error", 32'(o_error[1]), 32'd0);
    chk("ovf_restart_busy", 32'(o_busy[1]), 32'd1);

    repeat (3) @(posedge clk1);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
